// File: rtl/ahblite_decode_mux.sv
// AHB-Lite decoder/response mux; HSEL_S is combinational, data-phase select is registered on HREADY.
// Unmapped active transfers get a two-cycle ERROR from the default slave; slave wait states hold the data-phase select.
module ahblite_decode_mux #(
   parameter int                 NSLV     = 6,
   parameter logic [NSLV*32-1:0] SLV_BASE = {32'h40060000, 32'h40040000, 32'h40000010,
                                             32'h40050000, 32'h20000000, 32'h00000000},
   parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFFF0,
                                             32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000},
   parameter logic [NSLV-1:0]    SLV_EN   = {NSLV{1'b1}}
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   output logic [NSLV-1:0]      HSEL_S,
   input  logic [NSLV*32-1:0]   HRDATA_S,
   input  logic [NSLV-1:0]      HREADYOUT_S,
   input  logic [NSLV-1:0]      HRESP_S,
   output logic [31:0]          HRDATA,
   output logic                 HREADY,
   output logic                 HRESP,
   output logic [15:0]          ERR_CNT,
   output logic [31:0]          ERR_ADDR
);
   localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

   typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

   dstate_t       state_q;
   dstate_t       state_d;
   logic [IW-1:0] hit_idx;
   logic          any_hit;
   logic [IW-1:0] sel_q;
   logic          dflt_q;
   logic          active_q;
   logic [31:0]   slv_rdata;
   logic          slv_ready;
   logic          slv_resp;
   logic          err_start;
   logic [15:0]   err_cnt_q;
   logic [31:0]   err_addr_q;
   logic          unused_htrans0;

   assign unused_htrans0 = HTRANS[0];

   // Scan from the top down so the lowest-index hit is the one left standing.
   always_comb begin
      hit_idx = '0;
      any_hit = 1'b0;
      HSEL_S  = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (SLV_EN[i] &&
             ((HADDR & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32]))) begin
            hit_idx   = IW'(i);
            any_hit   = 1'b1;
            HSEL_S    = '0;
            HSEL_S[i] = 1'b1;
         end
      end
   end

   always_comb begin
      slv_rdata = '0;
      slv_ready = 1'b1;
      slv_resp  = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel_q == IW'(i)) begin
            slv_rdata = HRDATA_S[i*32 +: 32];
            slv_ready = HREADYOUT_S[i];
            slv_resp  = HRESP_S[i];
         end
      end
   end

   always_comb begin
      HRDATA = slv_rdata;
      HREADY = slv_ready;
      HRESP  = slv_resp;
      if (dflt_q) begin
         HRDATA = '0;
         HREADY = 1'b1;
         HRESP  = 1'b0;
         if (active_q) begin
            case (state_q)
               D_ERR1: begin
                  HREADY = 1'b0;
                  HRESP  = 1'b1;
               end
               D_ERR2: begin
                  HREADY = 1'b1;
                  HRESP  = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign err_start = HREADY && !any_hit && HTRANS[1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         D_IDLE:  if (err_start) state_d = D_ERR1;
         D_ERR1:  state_d = D_ERR2;
         D_ERR2:  state_d = err_start ? D_ERR1 : D_IDLE;
         default: state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sel_q      <= '0;
         dflt_q     <= 1'b1;
         active_q   <= 1'b0;
         state_q    <= D_IDLE;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (HREADY) begin
            sel_q    <= hit_idx;
            dflt_q   <= !any_hit;
            active_q <= HTRANS[1];
         end
         if (err_start) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            err_addr_q <= HADDR;
         end
      end
   end

   assign ERR_CNT  = err_cnt_q;
   assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Bench for ahblite_decode_mux: an abstract data-phase model checked every cycle, plus directed literal checks.
module tb_ahblite_decode_mux;
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;

   localparam logic [31:0] BASE [0:5] = '{32'h00000000, 32'h20000000, 32'h40050000,
                                          32'h40000010, 32'h40040000, 32'h40060000};
   localparam logic [31:0] MASK [0:5] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
                                          32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000};

   logic         HCLK;
   logic         HRESET;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic [5:0]   HSEL_S;
   logic [191:0] HRDATA_S;
   logic [5:0]   HREADYOUT_S;
   logic [5:0]   HRESP_S;
   logic [31:0]  HRDATA;
   logic         HREADY;
   logic         HRESP;
   logic [15:0]  ERR_CNT;
   logic [31:0]  ERR_ADDR;

   int total = 0;
   int bad   = 0;

   // Model state: which slave owns the data phase (-1 = default slave) and
   // how many cycles of ERROR response remain (2 = first, 1 = second).
   bit          m_valid = 1'b0;
   int          m_slave;
   int          m_err_left;
   int          m_cnt;
   logic [31:0] m_addr;

   ahblite_decode_mux dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL_S      (HSEL_S),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .ERR_CNT     (ERR_CNT),
      .ERR_ADDR    (ERR_ADDR)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < 6; i++)
         if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         int          idx;
         logic [5:0]  e_sel;
         logic        e_rdy;
         logic        e_resp;
         logic [31:0] e_dat;
         @(negedge HCLK);
         idx   = decode(HADDR);
         e_sel = '0;
         if (idx >= 0) e_sel[idx] = 1'b1;
         e_rdy = 1'b1;
         if (m_valid) begin
            if (m_slave >= 0) begin
               e_rdy  = HREADYOUT_S[m_slave];
               e_resp = HRESP_S[m_slave];
               e_dat  = HRDATA_S[m_slave*32 +: 32];
            end else begin
               e_rdy  = (m_err_left != 2);
               e_resp = (m_err_left != 0);
               e_dat  = 32'h0;
            end
            check("m_hsel",     32'(HSEL_S),   32'(e_sel));
            check("m_hready",   32'(HREADY),   32'(e_rdy));
            check("m_hresp",    32'(HRESP),    32'(e_resp));
            check("m_hrdata",   HRDATA,        e_dat);
            check("m_err_cnt",  32'(ERR_CNT),  32'(m_cnt));
            check("m_err_addr", ERR_ADDR,      m_addr);
         end
         if (HRESET) begin
            m_valid    = 1'b1;
            m_slave    = -1;
            m_err_left = 0;
            m_cnt      = 0;
            m_addr     = 32'h0;
         end else if (m_valid) begin
            if (e_rdy) begin
               m_slave = idx;
               if (idx < 0 && HTRANS[1]) begin
                  m_err_left = 2;
                  if (m_cnt < 65535) m_cnt++;
                  m_addr = HADDR;
               end else begin
                  m_err_left = 0;
               end
            end else if (m_err_left == 2) begin
               m_err_left = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] t);
      HADDR  = a;
      HTRANS = t;
      #1;
   endtask

   initial begin
      HRESET      = 1'b1;
      HADDR       = 32'h0;
      HTRANS      = IDLE;
      HREADYOUT_S = '1;
      HRESP_S     = '0;
      for (int i = 0; i < 6; i++) HRDATA_S[i*32 +: 32] = {4'hA, 4'(i), 24'h00BEEF};

      // reset state
      drive(32'h0, IDLE);
      tick();
      tick();
      check("rst_hsel",   32'(HSEL_S),  32'h01);
      check("rst_hready", 32'(HREADY),  32'h1);
      check("rst_hresp",  32'(HRESP),   32'h0);
      check("rst_hrdata", HRDATA,       32'h0);
      check("rst_errcnt", 32'(ERR_CNT), 32'h0);
      HRESET = 1'b0;

      // mapped read to slave 1
      drive(32'h20000004, NONSEQ);
      check("rd_hsel", 32'(HSEL_S), 32'h02);
      HRESP_S[1] = 1'b1;
      tick();
      check("rd_hrdata", HRDATA,      32'hA100BEEF);
      check("rd_hready", 32'(HREADY), 32'h1);
      check("rd_hresp",  32'(HRESP),  32'h1);
      HRESP_S[1] = 1'b0;

      // 16-byte window edge
      drive(32'h4000001C, IDLE);
      check("uart_in",  32'(HSEL_S), 32'h08);
      drive(32'h40000020, IDLE);
      check("uart_out", 32'(HSEL_S), 32'h00);
      tick();
      check("idle_unmapped_ok", 32'(HRESP), 32'h0);

      // unmapped NONSEQ then same address IDLE
      drive(32'h30000000, NONSEQ);
      tick();
      check("err1_hready", 32'(HREADY),  32'h0);
      check("err1_hresp",  32'(HRESP),   32'h1);
      check("err_cnt1",    32'(ERR_CNT), 32'h1);
      check("err_addr1",   ERR_ADDR,     32'h30000000);
      drive(32'h0, IDLE);
      tick();
      check("err2_hready", 32'(HREADY), 32'h1);
      check("err2_hresp",  32'(HRESP),  32'h1);
      tick();
      check("after_err_hresp", 32'(HRESP), 32'h0);
      check("after_err_data",  HRDATA,     32'hA000BEEF);
      drive(32'h30000000, IDLE);
      tick();
      check("idle_unm_hready", 32'(HREADY),  32'h1);
      check("idle_unm_hresp",  32'(HRESP),   32'h0);
      check("idle_unm_cnt",    32'(ERR_CNT), 32'h1);

      // slave 2 stalls for three cycles while the next address targets slave 4
      drive(32'h40050000, NONSEQ);
      tick();
      HREADYOUT_S[2] = 1'b0;
      drive(32'h40040000, NONSEQ);
      for (int k = 0; k < 3; k++) begin
         check("wait_hready", 32'(HREADY), 32'h0);
         check("wait_hrdata", HRDATA,      32'hA200BEEF);
         tick();
      end
      HREADYOUT_S[2] = 1'b1;
      #1;
      check("release_hready", 32'(HREADY), 32'h1);
      check("release_hrdata", HRDATA,      32'hA200BEEF);
      tick();
      drive(32'h0, IDLE);
      check("next_slave_data", HRDATA, 32'hA400BEEF);
      tick();

      // back-to-back errors from a clean count
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      check("rst2_cnt", 32'(ERR_CNT), 32'h0);
      drive(32'h30000000, NONSEQ);
      tick();
      check("b2b_e1_rdy", 32'({HREADY, HRESP}), 32'h1);
      drive(32'h30001000, NONSEQ);
      tick();
      check("b2b_e2_rdy", 32'({HREADY, HRESP}), 32'h3);
      tick();
      check("b2b_e3_rdy", 32'({HREADY, HRESP}), 32'h1);
      drive(32'h0, IDLE);
      tick();
      check("b2b_e4_rdy", 32'({HREADY, HRESP}), 32'h3);
      tick();
      check("b2b_done",   32'({HREADY, HRESP}), 32'h2);
      check("b2b_cnt",    32'(ERR_CNT),          32'h2);
      check("b2b_addr",   ERR_ADDR,              32'h30001000);

      // saturation: preload the counter near the top, then reset mid-error
      force dut.err_cnt_q = 16'hFFFD;
      m_cnt = 32'h0000FFFD;
      #1;
      release dut.err_cnt_q;
      drive(32'h30000000, NONSEQ);
      tick();
      tick();
      tick();
      check("sat_reach", 32'(ERR_CNT), 32'hFFFF);
      tick();
      tick();
      check("sat_hold",   32'(ERR_CNT), 32'hFFFF);
      check("sat_err1",   32'({HREADY, HRESP}), 32'h1);
      HRESET = 1'b1;
      tick();
      check("abort_cnt",    32'(ERR_CNT), 32'h0);
      check("abort_hready", 32'(HREADY),  32'h1);
      check("abort_hresp",  32'(HRESP),   32'h0);
      check("abort_addr",   ERR_ADDR,     32'h0);
      HRESET = 1'b0;
      drive(32'h0, IDLE);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule
